// File: rtl/minterm_pkg.sv
// Shared types and widths for the minterm scanner: FSM state encoding and
// the code/mask/count widths of a 4-input truth-table read-back.
package minterm_pkg;

  localparam int N_IN   = 4;
  localparam int MASK_W = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage : minterm_pkg

// File: rtl/minterm_scanner_if.sv
// Harness-side bundle of the scanner: start/done handshake, FUT drive/sense
// lines and the extracted result.
interface minterm_scanner_if;

  logic        start;
  logic        y_in;
  logic        d_out;
  logic        c_out;
  logic        b_out;
  logic        a_out;
  logic        busy;
  logic        done;
  logic [15:0] mask;
  logic [4:0]  count;

  modport slave (
    input  start, y_in,
    output d_out, c_out, b_out, a_out, busy, done, mask, count
  );

  modport master (
    output start, y_in,
    input  d_out, c_out, b_out, a_out, busy, done, mask, count
  );

endinterface : minterm_scanner_if

// File: rtl/minterm_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; times the settle interval
// between driving a code and sampling the FUT output.
module minterm_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule : minterm_settle_timer

// File: rtl/minterm_scanner.sv
// Walks a 4-input FUT through codes 0..15, samples Y after SETTLE idle
// cycles per code, and reports the minterm mask and its popcount.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  minterm_scanner_if.slave   bus
);

  // A timer loaded with SETTLE-1 reaches zero after SETTLE cycles in ST_SETTLE.
  localparam logic [3:0]      TMR_LOAD  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam state_e          ST_WAIT   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic                start_ok;

  // A start is honoured only when no scan is running.
  assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  minterm_settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE:   if (start_ok) state_d = ST_WAIT;
      ST_SETTLE: if (tmr_zero) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_WAIT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    mask_d   = mask_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start_ok) begin
          idx_d    = '0;
          mask_d   = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        tmr_dec = !tmr_zero;
      end
      ST_SAMPLE: begin
        mask_d[idx_q] = bus.y_in;
        count_d       = count_q + CNT_W'(bus.y_in);
        if (idx_q == IDX_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The mask is plain result state, so it clears on reset with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.d_out = idx_q[3];
  assign bus.c_out = idx_q[2];
  assign bus.b_out = idx_q[1];
  assign bus.a_out = idx_q[0];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mask  = mask_q;
  assign bus.count = count_q;

endmodule : minterm_scanner
